// File: rtl/mem_access_pkg.sv
// Shared types and decode helpers for the memory access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        SzByte = 2'd0,
        SzHalf = 2'd1,
        SzWord = 2'd2
    } size_e;

    // funct3[1:0] selects the access size, funct3[2] selects zero extension.
    localparam logic [1:0]  F3_SZ_BYTE      = 2'b00;
    localparam logic [1:0]  F3_SZ_HALF      = 2'b01;
    localparam int unsigned F3_UNSIGNED_BIT = 2;

    // Fetches are always words; unused size codes fall back to word.
    function automatic size_e decode_size(input logic fetch, input logic [2:0] funct3);
        size_e sz;
        if (fetch) begin
            sz = SzWord;
        end else begin
            case (funct3[1:0])
                F3_SZ_BYTE: sz = SzByte;
                F3_SZ_HALF: sz = SzHalf;
                default:    sz = SzWord;
            endcase
        end
        return sz;
    endfunction

    function automatic logic decode_signed(input logic fetch, input logic [2:0] funct3);
        return !fetch && !funct3[F3_UNSIGNED_BIT];
    endfunction

    function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SzByte:  be = 4'b0001 << addr_lo;
            SzHalf:  be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'hF;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes so the enabled lanes carry it.
    function automatic logic [31:0] store_lanes(input size_e size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SzByte:  lanes = {4{data[7:0]}};
            SzHalf:  lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SzHalf:  mis = addr_lo[0];
            SzWord:  mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Load lane select plus sign/zero extension of the returned bus word.
module load_aligner
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  size_e       i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane and extend it to a full word.
    always_comb begin
        w_shifted = i_rdata >> {i_addr_lo, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_data    = i_rdata;
        case (i_size)
            SzByte:  o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SzHalf:  o_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: one request/ack bus transaction per control access.
// Optional alignment checking is enabled with MEM_ACCESS_UNIT_ALIGN_CHECK_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            fetch,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            mem_complete,
    output logic            misaligned,
    output logic            access_fault,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic            bus_err,
    input  logic [XLEN-1:0] bus_rdata
);

    state_e      r_state;
    logic [1:0]  r_addr_lo;
    size_e       r_size;
    logic        r_signed;
    logic [31:0] r_rdata;
    logic        r_mem_complete;
    logic        r_access_fault;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;

    size_e       w_size;
    logic        w_signed;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_lanes;
    logic        w_misal;
    logic [31:0] w_load_data;

    // Decode the incoming request; write takes priority when both are high.
    always_comb begin
        w_size   = decode_size(fetch, funct3);
        w_signed = decode_signed(fetch, funct3);
        w_we     = mem_write;
        w_be     = w_we ? byte_en(w_size, addr[1:0]) : 4'hF;
        w_lanes  = store_lanes(w_size, wdata);
    end

`ifdef MEM_ACCESS_UNIT_ALIGN_CHECK_EN
    logic r_misaligned;
    assign w_misal    = is_misaligned(w_size, addr[1:0]);
    assign misaligned = r_misaligned;
`else
    assign w_misal    = 1'b0;
    assign misaligned = 1'b0;
`endif

    load_aligner u_load_aligner (
        .i_rdata   (bus_rdata),
        .i_addr_lo (r_addr_lo),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .o_data    (w_load_data)
    );

    // Access sequencer with registered bus outputs and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_addr_lo      <= 2'b00;
            r_size         <= SzByte;
            r_signed       <= 1'b0;
            r_rdata        <= '0;
            r_mem_complete <= 1'b0;
            r_access_fault <= 1'b0;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_be       <= 4'h0;
            r_bus_wdata    <= '0;
`ifdef MEM_ACCESS_UNIT_ALIGN_CHECK_EN
            r_misaligned   <= 1'b0;
`endif
        end else begin
            // Pulses live for exactly the DONE cycle.
            r_mem_complete <= 1'b0;
            r_access_fault <= 1'b0;
`ifdef MEM_ACCESS_UNIT_ALIGN_CHECK_EN
            r_misaligned   <= 1'b0;
`endif
            unique case (r_state)
                StIdle: begin
                    if (mem_read || mem_write) begin
                        r_addr_lo <= addr[1:0];
                        r_size    <= w_size;
                        r_signed  <= w_signed;
                        if (w_misal) begin
`ifdef MEM_ACCESS_UNIT_ALIGN_CHECK_EN
                            r_misaligned <= 1'b1;
`endif
                            r_state <= StDone;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= w_we;
                            r_bus_addr  <= {addr[31:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_lanes;
                            r_state     <= StWait;
                        end
                    end
                end
                StWait: begin
                    // No abort path: the transaction runs until the bus acks.
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        if (bus_err) begin
                            r_access_fault <= 1'b1;
                        end else begin
                            r_mem_complete <= 1'b1;
                            if (!r_bus_we) begin
                                r_rdata <= w_load_data;
                            end
                        end
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign rdata        = r_rdata;
    assign mem_complete = r_mem_complete;
    assign access_fault = r_access_fault;
    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_be       = r_bus_be;
    assign bus_wdata    = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected outcomes,
// a bus responder and a completion monitor pop and compare.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic        fetch;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_complete;
    logic        misaligned;
    logic        access_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    mem_access_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .fetch        (fetch),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .mem_complete (mem_complete),
        .misaligned   (misaligned),
        .access_fault (access_fault),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err),
        .bus_rdata    (bus_rdata)
    );

    // kind: 0 complete, 1 access fault, 2 misaligned
    typedef struct {
        int          kind;
        logic [31:0] rdata;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] brd;
        logic [3:0]  be;
        logic        we;
        logic        err;
        int          dly;
    } item_t;

    item_t       q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          pulses = 0;
    int          n_txn = 0;
    int          cyc = 0;
    int          ack_cyc = 0;
    logic [31:0] model_rdata = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // Reference model: expected bus fields and result from the ISA-level rules.
    task automatic build(input logic wr, input logic ft, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                         input logic err, input int dly, output item_t it);
        int          n;
        int          off;
        logic [31:0] mask;
        logic [31:0] v;
        logic [3:0]  full;
        logic        mis;
        n    = ft ? 4 : (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = (n == 1) ? int'(a[1:0]) : (n == 2) ? int'(a[1]) * 2 : 0;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        v    = (brd >> (8 * off)) & mask;
        if (!ft && !f3[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
        full = (n == 1) ? 4'h1 : (n == 2) ? 4'h3 : 4'hF;
`ifdef MEM_ACCESS_UNIT_ALIGN_CHECK_EN
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        it.we     = wr;
        it.be     = wr ? 4'(full << off) : 4'hF;
        it.baddr  = a & 32'hFFFF_FFFC;
        it.bwdata = (n == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                    (n == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
        it.brd    = brd;
        it.err    = err;
        it.dly    = dly;
        it.kind   = mis ? 2 : (err ? 1 : 0);
        if (it.kind == 0 && !wr) model_rdata = v;
        it.rdata  = model_rdata;
    endtask

    // Issue one access; called and returns at posedge+1.
    task automatic issue(input logic rd, input logic wr, input logic ft, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                         input logic err, input int dly, input bit hold, input bit chk_start);
        item_t it;
        int    p0;
        int    k;
        build(wr, ft, f3, a, wd, brd, err, dly, it);
        q.push_back(it);
        mem_read  = rd;
        mem_write = wr;
        fetch     = ft;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        p0        = pulses;
        if (chk_start) begin
            @(posedge clk);
            #1;
            chk("bus_req_next_cycle", {31'h0, bus_req}, (it.kind == 2) ? 32'h0 : 32'h1);
        end
        k = 0;
        while (pulses == p0 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (pulses == p0) begin
            n_checks++;
            $display("FAIL completion_timeout: got no pulse, expected pulse at addr 0x%08h", a);
            if (q.size() != 0) void'(q.pop_front());
        end
        if (!hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    // Bus responder: checks request fields, acks after the item's delay.
    initial begin
        item_t cur;
        int    wcnt;
        bit    in_txn;
        in_txn    = 1'b0;
        wcnt      = 0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            bus_err = 1'b0;
            if (!rst_n) begin
                in_txn = 1'b0;
            end else if (bus_req) begin
                if (!in_txn) begin
                    n_txn++;
                    in_txn = 1'b1;
                    if (q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_bus_req: got bus_req=1, expected 0");
                        cur.err = 1'b0;
                        cur.brd = 32'h0;
                        wcnt    = 0;
                    end else begin
                        cur  = q[0];
                        wcnt = cur.dly;
                        chk("bus_addr", bus_addr, cur.baddr);
                        chk("bus_be", {28'h0, bus_be}, {28'h0, cur.be});
                        chk("bus_we", {31'h0, bus_we}, {31'h0, cur.we});
                        if (cur.we) chk("bus_wdata", bus_wdata, cur.bwdata);
                    end
                end
                if (wcnt == 0) begin
                    bus_ack   = 1'b1;
                    bus_err   = cur.err;
                    bus_rdata = cur.brd;
                    in_txn    = 1'b0;
                    ack_cyc   = cyc;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every pulse.
    initial begin
        item_t it;
        int    act_kind;
        forever begin
            @(negedge clk);
            if (rst_n && (mem_complete || access_fault || misaligned)) begin
                pulses++;
                act_kind = mem_complete ? 0 : (access_fault ? 1 : 2);
                chk("pulse_onehot", 32'($countones({mem_complete, access_fault, misaligned})), 32'd1);
                chk("bus_idle_in_done", {31'h0, bus_req}, 32'h0);
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pulse: got kind %0d, expected none", act_kind);
                end else begin
                    it = q.pop_front();
                    chk("pulse_kind", 32'(act_kind), 32'(it.kind));
                    chk("rdata", rdata, it.rdata);
                    if (it.kind != 2) chk("ack_to_pulse", 32'(cyc), 32'(ack_cyc + 1));
                end
            end
        end
    end

    initial begin
        logic [2:0]  f3tab [8];
        item_t       rit;
        int          t0;
        int          p0;
        int          op;
        logic [31:0] ra;
        f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        fetch     = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_complete", {31'h0, mem_complete}, 32'h0);
        chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
        chk("rst_access_fault", {31'h0, access_fault}, 32'h0);
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        issue(1, 0, 1, 3'b010, 32'h100, 32'h0, 32'h0050_0093, 0, 3, 0, 1);
        chk("fetch_word", rdata, 32'h0050_0093);
        issue(1, 0, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 0, 1, 0, 1);
        chk("lb_sign", rdata, 32'hFFFF_FF80);
        issue(1, 0, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 0, 0, 0, 1);
        chk("lbu_zero", rdata, 32'h0000_0080);
        issue(1, 0, 0, 3'b001, 32'h202, 32'h0, 32'h80FF_1234, 0, 2, 0, 1);
        chk("lh_sign", rdata, 32'hFFFF_80FF);
        issue(0, 1, 0, 3'b001, 32'h402, 32'h0000_BEEF, 32'h0, 0, 1, 0, 1);
        chk("sh_keeps_rdata", rdata, 32'hFFFF_80FF);
        issue(1, 0, 0, 3'b010, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 1);
        issue(1, 1, 0, 3'b000, 32'h601, 32'h0000_00A5, 32'h0, 0, 0, 0, 1);

        // Held read across three zero-wait fetches, the middle one faulting
        t0 = n_txn;
        issue(1, 0, 1, 3'b010, 32'h500, 32'h0, 32'h1111_1111, 0, 0, 1, 1);
        issue(1, 0, 1, 3'b010, 32'h500, 32'h0, 32'h2222_2222, 1, 0, 1, 0);
        chk("fault_keeps_rdata", rdata, 32'h1111_1111);
        issue(1, 0, 1, 3'b010, 32'h500, 32'h0, 32'h3333_3333, 0, 0, 0, 0);
        chk("held_txn_count", 32'(n_txn - t0), 32'd3);
        chk("held_last_rdata", rdata, 32'h3333_3333);

        // Reset in the middle of a bus wait
        build(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b0, 20, rit);
        q.push_back(rit);
        mem_read = 1'b1;
        fetch    = 1'b1;
        addr     = 32'h300;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("reset_drops_req", {31'h0, bus_req}, 32'h0);
        chk("reset_clears_rdata", rdata, 32'h0);
        q.delete();
        model_rdata = 32'h0;
        mem_read    = 1'b0;
        fetch       = 1'b0;
        p0          = pulses;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_pulse_after_reset", 32'(pulses), 32'(p0));
        issue(1, 0, 0, 3'b101, 32'h712, 32'h0, 32'h9876_5432, 0, 1, 0, 1);
        chk("clean_after_reset", rdata, 32'h0000_9876);

        // Randomized accesses
        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 3));
            ra = $urandom;
            issue((op != 2) ? 1'b1 : 1'b0, (op >= 2) ? 1'b1 : 1'b0, (op == 0) ? 1'b1 : 1'b0,
                  f3tab[$urandom_range(0, 7)], ra, $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, int'($urandom_range(0, 3)), 0, 1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle core's memory access unit, sitting directly between the control FSM and the external memory bus. Consumes `mem_read`/`mem_write`, the selected address and store data, and runs one request/acknowledge bus transaction per access. Generates byte enables and store lane replication, extracts and extends load data, and returns a single-cycle `mem_complete` pulse that steps the control sequencer. Serves both instruction fetch and LOAD/STORE.

## Interface
- `XLEN`, 32: address/data width; only 32 is supported.
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  read request from control; level, held until `mem_complete`.
- `mem_write`  in  1  write request from control; level, held until `mem_complete`.
- `fetch`  in  1  access is instruction fetch (addr_sel == PC); forces word size.
- `funct3`  in  3  load/store size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data (rs2).
- `rdata`  out  32  extended load data / raw fetch word; registered.
- `mem_complete`  out  1  one-cycle pulse: access finished, `rdata` valid.
- `misaligned`  out  1  one-cycle pulse: access rejected for alignment.
- `access_fault`  out  1  one-cycle pulse: bus returned error.
- `bus_req`  out  1  transaction request; held until `bus_ack`.
- `bus_we`  out  1  write strobe.
- `bus_addr`  out  32  word-aligned address (`addr[31:2]`, 2'b00).
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  transaction complete.
- `bus_err`  in  1  error; valid only with `bus_ack`.
- `bus_rdata`  in  32  read word; valid with `bus_ack`.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if `mem_read|mem_write`, latch addr/size/sign/we/be/wdata, go WAIT (or DONE with misaligned, see Configuration).
- WAIT: `bus_req`=1, bus outputs stable from latched values; on `bus_ack` capture data, go DONE.
- DONE: pulse exactly one of `mem_complete`/`access_fault`/`misaligned`; requests ignored this cycle; go IDLE.
- Both read and write high: write wins.
- Fetch: word size, `bus_be`=4'hF, `rdata` = raw word.
- Store: SB `bus_wdata`={4{wdata[7:0]}}, `bus_be`=4'b0001<<addr[1:0]; SH {2{wdata[15:0]}}, 4'b0011<<{addr[1],1'b0}; SW wdata, 4'hF.
- Load: select byte `addr[1:0]` / halfword `addr[1]`; B/H sign-extend, BU/HU zero-extend, W pass-through.
- Reads use `bus_be`=4'hF. Funct3 011/110/111: treated as W, no flag (decode owns illegal-instruction detection).
- `rdata` updates only on successful read ack; holds otherwise (stores, faults, misaligned leave it unchanged).
- Once WAIT is entered the transaction always completes; dropping `mem_read`/`mem_write` does not abort it.

## Timing
- Reset: state IDLE; `rdata`=0, `mem_complete`=`misaligned`=`access_fault`=`bus_req`=`bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0.
- Request seen in IDLE at cycle N -> `bus_req` high from N+1 (registered).
- `bus_ack` at cycle M -> `mem_complete` at M+1; minimum request-to-complete latency 2 cycles (zero-wait bus acks in N+1).
- Back-to-back: control holds the next request through DONE; it is accepted in IDLE the cycle after DONE. Exactly one bus transaction per pulse.
- `bus_err` with `bus_ack` -> `access_fault` at M+1, no `mem_complete`.
- Async reset mid-WAIT: `bus_req` drops immediately; no completion pulse after release.

## Configuration
- `MEM_ACCESS_UNIT_ALIGN_CHECK_EN` defined: H at odd address, W/fetch with `addr[1:0]`!=0 -> IDLE goes straight to DONE, `misaligned` pulse, no `bus_req`.
- Undefined: no check; low address bits ignored for size alignment (H uses `addr[1]`, W uses aligned word); `misaligned` tied 0.

## Structure
- Package `mem_access_pkg`: state enum, size/sign encoding constants derived from funct3, byte-enable helper function.
- Sub-module `load_aligner`: combinational lane select plus sign/zero extension (`bus_rdata`, `addr[1:0]`, size, sign -> 32-bit result).

## Test plan
- Fetch 0x100, ack 3 cycles after `bus_req`, rdata 0x00500093 -> `bus_addr` 0x100, `bus_be` F, `bus_we` 0; `mem_complete` one cycle after ack; `rdata` 0x00500093.
- LB 0x203, bus_rdata 0x80FF1234 -> `rdata` 0xFFFFFF80; LBU same -> 0x00000080; LH 0x202 -> 0xFFFF80FF.
- SH 0x402, wdata 0x0000BEEF -> `bus_addr` 0x400, `bus_be` 4'b1100, `bus_wdata` 0xBEEFBEEF, `bus_we` 1.
- LW 0x101: with macro -> `misaligned` pulse, no `bus_req`; without -> `bus_addr` 0x100, normal completion.
- `mem_read` held across three fetches with zero-wait ack -> exactly three transactions, one `mem_complete` each, one idle bus cycle in DONE; `bus_err`=1 on second -> `access_fault`, `rdata` unchanged.
- `rst_n` low during WAIT -> `bus_req` 0 in same cycle, no `mem_complete` after release, next request starts cleanly.
